// File: rtl/sequence_game_engine.sv
// sequence_game_engine: memory-sequence game core. Grows an LFSR-driven
// symbol sequence one symbol per round, replays it on a one-hot prompt bus,
// then checks the player's presses symbol by symbol, tracking score/lives.
// Ports: clock, reset (async, active-high), go (start/restart level),
//   seed (LFSR seed, sampled at game start), btn (debounced buttons),
//   prompt (one-hot symbol while showing), score (saturating rounds won),
//   lives, level (sequence length), busy, pass_pulse, fail_pulse,
//   game_over, won.
// Optional build macro INPUT_TIMEOUT_EN: an idle player fails the round
// after TIMEOUT_TICKS display ticks without a correct press.
module sequence_game_engine #(
    parameter int NUM_CH        = 4,
    parameter int SYM_W         = $clog2(NUM_CH),
    parameter int MAX_LEN       = 16,
    parameter int TICK_DIV      = 50000000,
    parameter int START_LIVES   = 3,
    parameter int SCORE_W       = 8,
    parameter int TIMEOUT_TICKS = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         go,
    input  logic [15:0]                  seed,
    input  logic [NUM_CH-1:0]            btn,
    output logic [NUM_CH-1:0]            prompt,
    output logic [SCORE_W-1:0]           score,
    output logic [3:0]                   lives,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic                         busy,
    output logic                         pass_pulse,
    output logic                         fail_pulse,
    output logic                         game_over,
    output logic                         won
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_RELOAD = CW'(TICK_DIV - 1);

`ifdef INPUT_TIMEOUT_EN
    localparam int TO_CYC = TIMEOUT_TICKS * TICK_DIV;
    localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [TW-1:0] TO_RELOAD = TW'(TO_CYC - 1);
    logic [TW-1:0] to_q;
`else
    localparam int unused_timeout_ticks = TIMEOUT_TICKS;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_EXTEND, S_SHOW_ON, S_SHOW_OFF,
        S_INPUT, S_PASS, S_FAIL, S_OVER, S_WIN
    } state_t;

    state_t              state_q;
    logic [15:0]         lfsr_q;
    logic [15:0]         lfsr_d;
    logic [CW-1:0]       tick_q;
    logic [IW-1:0]       idx_q;
    logic [NUM_CH-1:0]   btn_q;
    logic [NUM_CH-1:0]   prompt_q;
    logic [SCORE_W-1:0]  score_q;
    logic [3:0]          lives_q;
    logic [LW-1:0]       level_q;
    logic                busy_q;
    logic                pass_q;
    logic                fail_q;
    logic                over_q;
    logic                won_q;
    logic [SYM_W-1:0]    seq_q [MAX_LEN];

    logic [SYM_W-1:0]    new_sym;
    logic [NUM_CH-1:0]   edge_w;
    logic [NUM_CH-1:0]   want_oh;
    logic [NUM_CH-1:0]   next_oh;
    logic [NUM_CH-1:0]   first_oh;
    logic                last_w;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SYM_W-1:0] s);
        return NUM_CH'(1) << s;
    endfunction

    // Galois right-shift step, taps 16'hB400
    assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign new_sym  = lfsr_d[SYM_W-1:0];
    assign edge_w   = btn & ~btn_q;
    assign last_w   = (LW'(idx_q) == level_q - LW'(1));
    assign want_oh  = onehot(seq_q[idx_q]);
    assign next_oh  = onehot(seq_q[idx_q + IW'(1)]);
    // The first symbol of a new game is written the same cycle it is shown
    assign first_oh = (level_q == '0) ? onehot(new_sym) : onehot(seq_q[0]);

    always_ff @(posedge clock) begin
        if (state_q == S_EXTEND) begin
            seq_q[level_q[IW-1:0]] <= new_sym;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lfsr_q   <= 16'hACE1;
            tick_q   <= '0;
            idx_q    <= '0;
            btn_q    <= '0;
            prompt_q <= '0;
            score_q  <= '0;
            lives_q  <= '0;
            level_q  <= '0;
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            over_q   <= 1'b0;
            won_q    <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
            to_q     <= '0;
`endif
        end else begin
            btn_q  <= btn;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_OVER, S_WIN: begin
                    if (go) begin
                        state_q  <= S_ARM;
                        score_q  <= '0;
                        lives_q  <= 4'(START_LIVES);
                        level_q  <= '0;
                        over_q   <= 1'b0;
                        won_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        prompt_q <= '0;
                        lfsr_q   <= (seed == 16'h0000) ? 16'hACE1 : seed;
                    end
                end
                S_ARM: begin
                    if (!go) state_q <= S_EXTEND;
                end
                S_EXTEND: begin
                    lfsr_q   <= lfsr_d;
                    level_q  <= level_q + LW'(1);
                    idx_q    <= '0;
                    prompt_q <= first_oh;
                    tick_q   <= TICK_RELOAD;
                    state_q  <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (tick_q == '0) begin
                        prompt_q <= '0;
                        tick_q   <= TICK_RELOAD;
                        state_q  <= S_SHOW_OFF;
                    end else begin
                        tick_q <= tick_q - CW'(1);
                    end
                end
                S_SHOW_OFF: begin
                    if (tick_q != '0) begin
                        tick_q <= tick_q - CW'(1);
                    end else if (last_w) begin
                        idx_q   <= '0;
                        state_q <= S_INPUT;
`ifdef INPUT_TIMEOUT_EN
                        to_q    <= TO_RELOAD;
`endif
                    end else begin
                        idx_q    <= idx_q + IW'(1);
                        prompt_q <= next_oh;
                        tick_q   <= TICK_RELOAD;
                        state_q  <= S_SHOW_ON;
                    end
                end
                S_INPUT: begin
                    if (edge_w != '0) begin
                        if (edge_w != want_oh) begin
                            state_q <= S_FAIL;
                            fail_q  <= 1'b1;
                            lives_q <= lives_q - 4'd1;
                        end else if (last_w) begin
                            state_q <= S_PASS;
                            pass_q  <= 1'b1;
                            if (score_q != '1) score_q <= score_q + SCORE_W'(1);
                        end else begin
                            idx_q <= idx_q + IW'(1);
`ifdef INPUT_TIMEOUT_EN
                            to_q  <= TO_RELOAD;
`endif
                        end
                    end
`ifdef INPUT_TIMEOUT_EN
                    else if (to_q == '0) begin
                        state_q <= S_FAIL;
                        fail_q  <= 1'b1;
                        lives_q <= lives_q - 4'd1;
                    end else begin
                        to_q <= to_q - TW'(1);
                    end
`endif
                end
                S_PASS: begin
                    if (level_q == LW'(MAX_LEN)) begin
                        state_q <= S_WIN;
                        won_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_EXTEND;
                    end
                end
                S_FAIL: begin
                    // lives already decremented on entry; zero means last life gone
                    if (lives_q == 4'd0) begin
                        state_q <= S_OVER;
                        over_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q    <= '0;
                        prompt_q <= first_oh;
                        tick_q   <= TICK_RELOAD;
                        state_q  <= S_SHOW_ON;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign prompt     = prompt_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign level      = level_q;
    assign busy       = busy_q;
    assign pass_pulse = pass_q;
    assign fail_pulse = fail_q;
    assign game_over  = over_q;
    assign won        = won_q;
endmodule

// File: tb/tb_sequence_game_engine.sv
// tb_sequence_game_engine: randomized self-checking bench for the
// sequence game engine against a queue-based model of the game rules.
module tb_sequence_game_engine;
    localparam int MAXL   = 4;
    localparam int TD     = 4;
    localparam int LIVES0 = 3;
    localparam int SW     = 2;
    localparam int SMAX   = (1 << SW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic [15:0]   seed = 16'h0;
    logic [3:0]    btn = 4'h0;
    logic [3:0]    prompt;
    logic [SW-1:0] score;
    logic [3:0]    lives;
    logic [2:0]    level;
    logic          busy, pass_pulse, fail_pulse, game_over, won;

    int vec = 0;
    int miss = 0;

    int          m_score, m_lives, m_level;
    bit          m_won;
    logic [15:0] m_lfsr;
    int          m_seq[$];

    always #5 clock = ~clock;

    sequence_game_engine #(
        .NUM_CH(4), .MAX_LEN(MAXL), .TICK_DIV(TD), .START_LIVES(LIVES0),
        .SCORE_W(SW), .TIMEOUT_TICKS(2)
    ) dut (
        .clock(clock), .reset(reset), .go(go), .seed(seed), .btn(btn),
        .prompt(prompt), .score(score), .lives(lives), .level(level),
        .busy(busy), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .game_over(game_over), .won(won)
    );

    initial begin
        #600000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v / 16'd2) ^ (((v % 16'd2) == 16'd1) ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] oh(input int s);
        logic [3:0] r;
        r = 4'b0001 << s;
        return r;
    endfunction

    task automatic m_extend();
        m_lfsr = lfsr_next(m_lfsr);
        m_seq.push_back(int'(m_lfsr % 16'd4));
        m_level++;
    endtask

    task automatic start_game(input logic [15:0] s, input string nm);
        seed = s;
        go = 1'b1;
        cyc(2);
        vec++;
        if ({busy, game_over, won} !== 3'b100 || score !== '0 ||
            lives !== 4'(LIVES0) || level !== 3'd0) begin
            miss++;
            $display("FAIL %s: busy/over/won=%b score=%0d lives=%0d level=%0d, want 100 0 %0d 0",
                     nm, {busy, game_over, won}, score, lives, level, LIVES0);
        end
        go = 1'b0;
        m_lfsr = (s == 16'h0) ? 16'hACE1 : s;
        m_seq.delete();
        m_level = 0;
        m_score = 0;
        m_lives = LIVES0;
        m_won = 1'b0;
        m_extend();
    endtask

    task automatic observe(input string nm);
        int n;
        n = 0;
        while (prompt == '0 && n < 40) begin
            cyc(1);
            n++;
        end
        vec++;
        if (prompt == '0) begin
            miss++;
            $display("FAIL %s_start: prompt stayed 0, want a symbol", nm);
            return;
        end
        vec++;
        if (level !== 3'(m_level)) begin
            miss++;
            $display("FAIL %s_level: level=%0d want %0d", nm, level, m_level);
        end
        foreach (m_seq[k]) begin
            for (int c = 0; c < TD; c++) begin
                vec++;
                if (prompt !== oh(m_seq[k])) begin
                    miss++;
                    $display("FAIL %s_on[%0d.%0d]: prompt=%b want %b",
                             nm, k, c, prompt, oh(m_seq[k]));
                end
                cyc(1);
            end
            for (int c = 0; c < TD; c++) begin
                vec++;
                if (prompt !== 4'b0000) begin
                    miss++;
                    $display("FAIL %s_off[%0d.%0d]: prompt=%b want 0000", nm, k, c, prompt);
                end
                cyc(1);
            end
        end
        vec++;
        if (busy !== 1'b1 || pass_pulse !== 1'b0 || fail_pulse !== 1'b0) begin
            miss++;
            $display("FAIL %s_input: busy/pass/fail=%b%b%b want 100",
                     nm, busy, pass_pulse, fail_pulse);
        end
    endtask

    // mode 0: all correct, 1: one wrong symbol, 2: two buttons at once
    task automatic do_round(input int mode, input bit watch, input string nm);
        int bad_k;
        if (watch) observe(nm);
        bad_k = (mode == 0) ? -1 : int'($urandom_range(m_level - 1, 0));
        for (int k = 0; k < m_level; k++) begin
            logic [3:0] want, other, p;
            want = oh(m_seq[k]);
            other = oh((m_seq[k] + int'($urandom_range(3, 1))) % 4);
            p = (k != bad_k) ? want : (mode == 1) ? other : (want | other);
            btn = p;
            cyc(1);
            if (k == bad_k) begin
                vec++;
                if (fail_pulse !== 1'b1 || pass_pulse !== 1'b0) begin
                    miss++;
                    $display("FAIL %s_failpulse: fail/pass=%b%b want 10 (btn=%b)",
                             nm, fail_pulse, pass_pulse, p);
                end
                btn = '0;
                cyc(1);
                m_lives--;
                vec++;
                if (fail_pulse !== 1'b0 || lives !== 4'(m_lives)) begin
                    miss++;
                    $display("FAIL %s_lives: fail=%b lives=%0d want 0 %0d",
                             nm, fail_pulse, lives, m_lives);
                end
                if (m_lives == 0) begin
                    vec++;
                    if (game_over !== 1'b1 || busy !== 1'b0 || won !== 1'b0 ||
                        prompt !== '0 || score !== SW'(m_score) ||
                        level !== 3'(m_level)) begin
                        miss++;
                        $display("FAIL %s_over: over/busy/won=%b prompt=%b score=%0d level=%0d want 100 0000 %0d %0d",
                                 nm, {game_over, busy, won}, prompt, score, level,
                                 m_score, m_level);
                    end
                end
                return;
            end
            if (k == m_level - 1) begin
                vec++;
                if (pass_pulse !== 1'b1 || fail_pulse !== 1'b0) begin
                    miss++;
                    $display("FAIL %s_passpulse: pass/fail=%b%b want 10",
                             nm, pass_pulse, fail_pulse);
                end
                btn = '0;
                cyc(1);
                m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
                vec++;
                if (pass_pulse !== 1'b0 || score !== SW'(m_score)) begin
                    miss++;
                    $display("FAIL %s_score: pass=%b score=%0d want 0 %0d",
                             nm, pass_pulse, score, m_score);
                end
                if (m_level == MAXL) begin
                    m_won = 1'b1;
                    vec++;
                    if (won !== 1'b1 || busy !== 1'b0 || game_over !== 1'b0 ||
                        prompt !== '0 || level !== 3'(MAXL)) begin
                        miss++;
                        $display("FAIL %s_win: won/busy/over=%b prompt=%b level=%0d want 100 0000 %0d",
                                 nm, {won, busy, game_over}, prompt, level, MAXL);
                    end
                end else begin
                    m_extend();
                end
                return;
            end
            vec++;
            if (pass_pulse !== 1'b0 || fail_pulse !== 1'b0 || busy !== 1'b1) begin
                miss++;
                $display("FAIL %s_mid[%0d]: pass/fail/busy=%b%b%b want 001",
                         nm, k, pass_pulse, fail_pulse, busy);
            end
            btn = '0;
            cyc(1);
        end
    endtask

    task automatic test_reset();
        cyc(2);
        vec++;
        if ({prompt, score, lives, level, busy, pass_pulse, fail_pulse,
             game_over, won} !== '0) begin
            miss++;
            $display("FAIL reset_held: outputs not all zero (prompt=%b score=%0d lives=%0d)",
                     prompt, score, lives);
        end
        reset = 1'b0;
        cyc(2);
        vec++;
        if ({prompt, score, lives, level, busy, pass_pulse, fail_pulse,
             game_over, won} !== '0) begin
            miss++;
            $display("FAIL reset_idle: outputs not all zero, busy=%b", busy);
        end
    endtask

    task automatic test_first_round();
        start_game(16'h0001, "first_arm");
        cyc(1);
        vec++;
        if (prompt !== 4'b0000 || level !== 3'd0) begin
            miss++;
            $display("FAIL first_extend: prompt=%b level=%0d want 0000 0", prompt, level);
        end
        cyc(1);
        vec++;
        if (prompt !== 4'b0001 || level !== 3'd1) begin
            miss++;
            $display("FAIL first_prompt: prompt=%b level=%0d want 0001 1", prompt, level);
        end
        observe("first_show");
        do_round(0, 1'b0, "first_play");
        do_round(0, 1'b1, "second_play");
    endtask

    task automatic test_fail_to_over();
        for (int i = 0; i < LIVES0; i++) begin
            do_round(1, 1'b1, "wrong");
        end
        cyc(3);
        vec++;
        if (game_over !== 1'b1 || busy !== 1'b0 || prompt !== '0) begin
            miss++;
            $display("FAIL over_hold: over/busy=%b%b prompt=%b want 10 0000",
                     game_over, busy, prompt);
        end
    endtask

    task automatic test_two_buttons();
        do_round(2, 1'b1, "two_btn");
        do_round(0, 1'b1, "after_two");
    endtask

    task automatic test_held();
        btn = oh(m_seq[0]);
        observe("held_show");
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            vec++;
            if (pass_pulse !== 1'b0 || fail_pulse !== 1'b0 || busy !== 1'b1 ||
                prompt !== '0 || level !== 3'(m_level)) begin
                miss++;
                $display("FAIL held_quiet[%0d]: pass/fail/busy=%b%b%b prompt=%b level=%0d",
                         i, pass_pulse, fail_pulse, busy, prompt, level);
            end
        end
        btn = '0;
        cyc(1);
        do_round(0, 1'b0, "held_play");
    endtask

    task automatic test_win();
        for (int r = 0; r <= MAXL && !m_won && m_lives > 0; r++) begin
            do_round(0, 1'b1, "win_round");
        end
        vec++;
        if (m_won != 1'b1 || won !== 1'b1 || score !== SW'(SMAX)) begin
            miss++;
            $display("FAIL win_reached: won=%b score=%0d want 1 %0d", won, score, SMAX);
        end
        start_game(16'($urandom), "win_restart");
    endtask

`ifdef INPUT_TIMEOUT_EN
    task automatic test_timeout();
        observe("to_show");
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            vec++;
            if (fail_pulse !== 1'b0) begin
                miss++;
                $display("FAIL timeout_early[%0d]: fail=%b want 0", i, fail_pulse);
            end
        end
        cyc(1);
        vec++;
        if (fail_pulse !== 1'b1) begin
            miss++;
            $display("FAIL timeout_fire: fail=%b want 1", fail_pulse);
        end
        cyc(1);
        m_lives--;
        vec++;
        if (lives !== 4'(m_lives)) begin
            miss++;
            $display("FAIL timeout_lives: lives=%0d want %0d", lives, m_lives);
        end
        do_round(0, 1'b1, "to_replay");
    endtask
`endif

    task automatic test_async_reset();
        int n;
        n = 0;
        while (prompt == '0 && n < 50) begin
            cyc(1);
            n++;
        end
        vec++;
        if (prompt == '0) begin
            miss++;
            $display("FAIL areset_show: prompt stayed 0, want a symbol");
        end
        cyc(1);
        reset = 1'b1;
        #1;
        vec++;
        if ({prompt, score, lives, level, busy, pass_pulse, fail_pulse,
             game_over, won} !== '0) begin
            miss++;
            $display("FAIL areset_now: prompt=%b lives=%0d level=%0d busy=%b want all 0",
                     prompt, lives, level, busy);
        end
        cyc(1);
        reset = 1'b0;
        cyc(1);
        vec++;
        if ({prompt, score, lives, level, busy, pass_pulse, fail_pulse,
             game_over, won} !== '0) begin
            miss++;
            $display("FAIL areset_idle: prompt=%b busy=%b want 0", prompt, busy);
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_fail_to_over();
        start_game(16'h0000, "seed0_arm");
        do_round(0, 1'b1, "seed0_r1");
        test_two_buttons();
        test_held();
        test_win();
`ifdef INPUT_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
